// File: rtl/cska_sub_seq_if.sv
// Handshake and result bundle for the block-serial carry-skip subtractor.
// The master drives operands and result acceptance; the slave is the subtractor.
interface cska_sub_seq_if #(
   parameter int WIDTH = 16
);
   localparam int N  = WIDTH / 4;
   localparam int SW = $clog2(N + 1);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic [SW-1:0]    skip_cnt;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, skip_cnt
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, skip_cnt
   );
endinterface

// File: rtl/cska_sub_seq.sv
// Block-serial carry-skip subtractor: diff = a - b - bin, one 4-bit block per
// clock, least-significant block first. Implemented as a + ~b + ~bin with a
// 4-bit ripple per block plus a skip path when the block propagate is all ones.
// Also reports borrow-out, signed overflow and the number of skipped blocks.
module cska_sub_seq #(
   parameter int WIDTH = 16
) (
   input logic          clk,
   input logic          rst_n,
   cska_sub_seq_if.slave bus
);
   localparam int N  = WIDTH / 4;
   localparam int BW = (N > 1) ? $clog2(N) : 1;
   localparam int SW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [BW-1:0]    r_blk;
   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_ovf;
   logic [SW-1:0]    r_skip;

   logic [3:0]       w_a_blk;
   logic [3:0]       w_nb_blk;
   logic [3:0]       w_p;
   logic [3:0]       w_sum;
   logic             w_skip;
   logic             w_cout;
   logic             w_ovf;

   // Current block: 4-bit ripple of a + ~b + carry, with the skip path OR-ed
   // into the carry-out (logically redundant with the ripple carry).
   always_comb begin
      logic [4:0] rc;
      w_a_blk  = r_a[4*r_blk +: 4];
      w_nb_blk = ~r_b[4*r_blk +: 4];
      w_p      = w_a_blk ^ w_nb_blk;
      w_sum    = '0;
      rc       = '0;
      rc[0]    = r_carry;
      for (int unsigned i = 0; i < 4; i++) begin
         w_sum[i]  = w_p[i] ^ rc[i];
         rc[i+1]   = (w_a_blk[i] & w_nb_blk[i]) | (w_p[i] & rc[i]);
      end
      w_skip = &w_p;
      w_cout = (w_skip & r_carry) | rc[4];
      // Only meaningful on the most-significant block.
      w_ovf  = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sum[3] != r_a[WIDTH-1]);
   end

   // Control FSM with registered handshake flags and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_carry     <= 1'b0;
         r_blk       <= '0;
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_skip      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a        <= bus.a;
                  r_b        <= bus.b;
                  r_carry    <= ~bus.bin;
                  r_blk      <= '0;
                  r_skip     <= '0;
                  r_diff     <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end
            end
            RUN: begin
               r_diff[4*r_blk +: 4] <= w_sum;
               r_carry              <= w_cout;
               if (w_skip) begin
                  r_skip <= r_skip + SW'(1);
               end
               if (r_blk == BW'(N - 1)) begin
                  r_bout      <= ~w_cout;
                  r_ovf       <= w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_blk <= r_blk + BW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.diff      = r_diff;
   assign bus.bout      = r_bout;
   assign bus.ovf       = r_ovf;
   assign bus.skip_cnt  = r_skip;
endmodule
